voice_alloc: RTL and testbench

//  Polyphonic voice allocator that sits between the MIDI decoder and the oscillator stack.
//  It replaces the shared-note voice counter with per-voice note registers.

---
 rtl/voice_alloc.sv | 106 ++++++++++
 tb/tb_voice_alloc.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/voice_alloc.sv
// voice_alloc: per-voice note allocator with retrigger, lowest-free allocation and oldest-voice stealing
module voice_alloc #(
   parameter int NUM_VOICES = 8,
   parameter int NOTE_BITS  = 7,
   parameter int AGE_BITS   = 4
) (
   input  logic                            clk_i,
   input  logic                            nrst_i,
   input  logic [NOTE_BITS-1:0]            note_i,
   input  logic                            noteOnStrb_i,
   input  logic                            noteOffStrb_i,
   output logic [NUM_VOICES*NOTE_BITS-1:0] voiceNote_o,
   output logic [NUM_VOICES-1:0]           voiceEn_o,
   output logic [$clog2(NUM_VOICES+1)-1:0] activeCount_o,
   output logic                            stealStrb_o
);
   localparam int IW = $clog2(NUM_VOICES);
   localparam int CW = $clog2(NUM_VOICES+1);
   localparam logic [AGE_BITS-1:0] AGE_MAX = '1;
   localparam logic [AGE_BITS-1:0] AGE_ONE = AGE_BITS'(1);

   logic [NOTE_BITS-1:0] note_q [NUM_VOICES];
   logic [NOTE_BITS-1:0] note_d [NUM_VOICES];
   logic [AGE_BITS-1:0]  age_q  [NUM_VOICES];
   logic [AGE_BITS-1:0]  age_d  [NUM_VOICES];
   logic [NUM_VOICES-1:0] en_q, en_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic steal_q, steal_d;
   logic hit_any, free_any;
   logic [IW-1:0] hit_idx, free_idx, old_idx, tgt;
   logic [AGE_BITS-1:0] old_age;

   // Candidate voices: holder of note_i, lowest free voice, oldest voice (ties to lowest index)
   always_comb begin
      hit_any  = 1'b0;
      hit_idx  = '0;
      free_any = 1'b0;
      free_idx = '0;
      old_idx  = '0;
      old_age  = age_q[0];
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (!hit_any && en_q[v] && note_q[v] == note_i) begin
            hit_any = 1'b1;
            hit_idx = IW'(v);
         end
         if (!free_any && !en_q[v]) begin
            free_any = 1'b1;
            free_idx = IW'(v);
         end
         if (age_q[v] > old_age) begin
            old_age = age_q[v];
            old_idx = IW'(v);
         end
      end
      tgt = hit_any ? hit_idx : free_any ? free_idx : old_idx;
   end

   always_comb begin
      en_d    = en_q;
      cnt_d   = '0;
      steal_d = noteOnStrb_i && !hit_any && !free_any;
      for (int v = 0; v < NUM_VOICES; v++) begin
         note_d[v] = note_q[v];
         age_d[v]  = age_q[v];
         if (noteOnStrb_i) begin
            if (tgt == IW'(v)) begin
               note_d[v] = note_i;
               en_d[v]   = 1'b1;
               age_d[v]  = '0;
            end else if (en_q[v] && age_q[v] != AGE_MAX) begin
               age_d[v] = age_q[v] + AGE_ONE;
            end
         end else if (noteOffStrb_i && hit_any && hit_idx == IW'(v)) begin
            en_d[v] = 1'b0;
         end
         cnt_d = cnt_d + CW'(en_d[v]);
      end
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            note_q[v] <= '0;
            age_q[v]  <= '0;
         end
         en_q    <= '0;
         cnt_q   <= '0;
         steal_q <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            note_q[v] <= note_d[v];
            age_q[v]  <= age_d[v];
         end
         en_q    <= en_d;
         cnt_q   <= cnt_d;
         steal_q <= steal_d;
      end
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note
      assign voiceNote_o[g*NOTE_BITS +: NOTE_BITS] = note_q[g];
   end
   assign voiceEn_o     = en_q;
   assign activeCount_o = cnt_q;
   assign stealStrb_o   = steal_q;
endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc: directed and random note traffic checked against a behavioural voice model
module tb_voice_alloc;
   localparam int NV = 4;
   localparam int NB = 7;

   logic clk_i = 1'b0;
   logic nrst_i = 1'b0;
   logic [NB-1:0] note_i = '0;
   logic noteOnStrb_i = 1'b0;
   logic noteOffStrb_i = 1'b0;
   logic [NV*NB-1:0] voiceNote_o;
   logic [NV-1:0] voiceEn_o;
   logic [2:0] activeCount_o;
   logic stealStrb_o;

   int checks = 0;
   int errors = 0;

   logic [NB-1:0] m_note [NV];
   bit m_en [NV];
   int m_age [NV];
   bit m_steal;

   voice_alloc #(.NUM_VOICES(NV), .NOTE_BITS(NB), .AGE_BITS(4)) dut (
      .clk_i(clk_i), .nrst_i(nrst_i), .note_i(note_i),
      .noteOnStrb_i(noteOnStrb_i), .noteOffStrb_i(noteOffStrb_i),
      .voiceNote_o(voiceNote_o), .voiceEn_o(voiceEn_o),
      .activeCount_o(activeCount_o), .stealStrb_o(stealStrb_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NV; i++) begin
         m_note[i] = '0;
         m_en[i] = 1'b0;
         m_age[i] = 0;
      end
      m_steal = 1'b0;
   endtask

   task automatic model_on(input logic [NB-1:0] n);
      int t = -1;
      for (int i = 0; i < NV; i++) if (t < 0 && m_en[i] && m_note[i] == n) t = i;
      for (int i = 0; i < NV; i++) if (t < 0 && !m_en[i]) t = i;
      if (t < 0) begin
         t = 0;
         for (int i = 1; i < NV; i++) if (m_age[i] > m_age[t]) t = i;
         m_steal = 1'b1;
      end
      for (int i = 0; i < NV; i++) begin
         if (i == t) begin
            m_note[i] = n;
            m_en[i] = 1'b1;
            m_age[i] = 0;
         end else if (m_en[i] && m_age[i] < 15) m_age[i]++;
      end
   endtask

   task automatic model_off(input logic [NB-1:0] n);
      for (int i = 0; i < NV; i++) if (m_en[i] && m_note[i] == n) m_en[i] = 1'b0;
   endtask

   task automatic check_all(input string tag);
      int en = 0;
      int cnt = 0;
      for (int i = 0; i < NV; i++) begin
         en |= int'(m_en[i]) << i;
         cnt += int'(m_en[i]);
         chk($sformatf("%s note v%0d", tag, i), int'(voiceNote_o[i*NB +: NB]), int'(m_note[i]));
      end
      chk({tag, " en"}, int'(voiceEn_o), en);
      chk({tag, " count"}, int'(activeCount_o), cnt);
      chk({tag, " steal"}, int'(stealStrb_o), int'(m_steal));
   endtask

   task automatic op(input bit on, input bit off, input int n, input string tag);
      @(negedge clk_i);
      noteOnStrb_i = on;
      noteOffStrb_i = off;
      note_i = NB'(n);
      m_steal = 1'b0;
      if (on) model_on(NB'(n));
      else if (off) model_off(NB'(n));
      @(negedge clk_i);
      noteOnStrb_i = 1'b0;
      noteOffStrb_i = 1'b0;
      check_all(tag);
      m_steal = 1'b0;
   endtask

   task automatic do_reset();
      #3 nrst_i = 1'b0;
      model_reset();
      #1 check_all("reset async");
      @(negedge clk_i);
      nrst_i = 1'b1;
   endtask

   initial begin
      model_reset();
      #12 check_all("reset initial");
      @(negedge clk_i);
      nrst_i = 1'b1;

      // Reset mid-play with three voices sounding
      op(1, 0, 10, "pre1");
      op(1, 0, 11, "pre2");
      op(1, 0, 12, "pre3");
      chk("pre count", int'(activeCount_o), 3);
      do_reset();
      chk("mid reset en", int'(voiceEn_o), 0);

      // Allocate
      op(1, 0, 60, "alloc60");
      op(1, 0, 64, "alloc64");
      op(1, 0, 67, "alloc67");
      chk("alloc en", int'(voiceEn_o), 4'b0111);
      chk("alloc v1", int'(voiceNote_o[NB +: NB]), 64);

      // Release then refill lowest free voice
      op(0, 1, 64, "off64");
      chk("off64 en", int'(voiceEn_o), 4'b0101);
      op(1, 0, 72, "on72");
      chk("on72 v1", int'(voiceNote_o[NB +: NB]), 72);

      // Steal oldest, then age saturation via retriggers
      do_reset();
      op(1, 0, 60, "s60");
      op(1, 0, 62, "s62");
      op(1, 0, 64, "s64");
      op(1, 0, 65, "s65");
      op(1, 0, 67, "s67");
      chk("steal v0", int'(voiceNote_o[0 +: NB]), 67);
      op(0, 0, 0, "steal idle");
      chk("steal one cycle", int'(stealStrb_o), 0);
      for (int k = 0; k < 20; k++) op(1, 0, 62, "retrig62");
      op(1, 0, 70, "sat steal");
      chk("sat steal v0", int'(voiceNote_o[0 +: NB]), 70);

      // Retrigger
      do_reset();
      op(1, 0, 60, "r60");
      op(1, 0, 62, "r62");
      op(1, 0, 60, "r60b");
      chk("retrig count", int'(activeCount_o), 2);
      op(1, 0, 64, "r64");
      op(1, 0, 65, "r65");
      op(1, 0, 67, "r67");
      chk("retrig steal v1", int'(voiceNote_o[NB +: NB]), 67);
      chk("retrig keep v0", int'(voiceNote_o[0 +: NB]), 60);

      // Edge strobes
      do_reset();
      op(1, 0, 60, "e60");
      op(0, 1, 50, "off50");
      op(1, 1, 70, "on70off60");
      chk("both en", int'(voiceEn_o), 4'b0011);

      // Random traffic over a small note range to exercise hits, misses and steals
      for (int k = 0; k < 400; k++) begin
         int kind = int'($urandom_range(0, 3));
         int n = 40 + int'($urandom_range(0, 7));
         op(kind == 0 || kind == 2, kind == 1 || kind == 2, n, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
